// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory-port arbiter slice.
package mem_arbiter_pkg;

  localparam int unsigned ADDRESS_BITS   = 32;
  localparam int unsigned CACHE_LINE_LEN = 128;

  typedef enum logic [1:0] {
    ARB_IDLE   = 2'd0,
    ARB_BUSY_I = 2'd1,
    ARB_BUSY_D = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWNER_I = 1'b0,
    OWNER_D = 1'b1
  } arb_owner_e;

endpackage

// File: rtl/ff.sv
// Generic register with synchronous active-high reset and load enable.
module ff #(
  parameter int unsigned     WIDTH       = 1,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Load d when enabled; reset wins.
  always_ff @(posedge clk) begin
    if (reset) q <= RESET_VALUE;
    else if (en) q <= d;
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the main-memory port between the icache
// refill path and the dcache fill/writeback path. The port is locked to
// the granted side until memory responds.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDRESS_BITS,
  parameter int unsigned LINE_W = CACHE_LINE_LEN
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_resp,
  output logic [LINE_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic              d_resp,
  output logic [LINE_W-1:0] d_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic              mem_resp,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic              busy
);

  arb_state_e  state_q, state_d;
  arb_owner_e  last_grant_q, last_grant_d;
  logic        grant_i, grant_d;
  logic [LINE_W-1:0] i_rdata_q, d_rdata_q;

  // State and round-robin pointer registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB_IDLE;
      last_grant_q <= OWNER_D;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
    end
  end

  // Arbitration in IDLE, release on memory response while busy.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_i      = 1'b0;
    grant_d      = 1'b0;
    unique case (state_q)
      ARB_IDLE: begin
        if (i_req && (!d_req || last_grant_q == OWNER_D)) begin
          grant_i      = 1'b1;
          state_d      = ARB_BUSY_I;
          last_grant_d = OWNER_I;
        end else if (d_req) begin
          grant_d      = 1'b1;
          state_d      = ARB_BUSY_D;
          last_grant_d = OWNER_D;
        end
      end
      ARB_BUSY_I, ARB_BUSY_D: begin
        if (mem_resp) state_d = ARB_IDLE;
      end
      default: state_d = ARB_IDLE;
    endcase
  end

  // Request latches, loaded only on grant so they stay frozen while busy.
  ff #(.WIDTH(ADDR_W), .RESET_VALUE('0)) u_addr_ff (
    .clk(clk), .reset(reset), .en(grant_i | grant_d),
    .d(grant_d ? d_addr : i_addr), .q(mem_addr)
  );

  ff #(.WIDTH(1), .RESET_VALUE('0)) u_we_ff (
    .clk(clk), .reset(reset), .en(grant_i | grant_d),
    .d(grant_d & d_we), .q(mem_we)
  );

  ff #(.WIDTH(LINE_W), .RESET_VALUE('0)) u_wdata_ff (
    .clk(clk), .reset(reset), .en(grant_d),
    .d(d_wdata), .q(mem_wdata)
  );

  // Response steering: only the current owner sees the pulse.
  assign i_resp = (state_q == ARB_BUSY_I) && mem_resp;
  assign d_resp = (state_q == ARB_BUSY_D) && mem_resp;

  // Last-delivered line per side, shown whenever no response is in flight.
  ff #(.WIDTH(LINE_W), .RESET_VALUE('0)) u_i_rdata_ff (
    .clk(clk), .reset(reset), .en(i_resp), .d(mem_rdata), .q(i_rdata_q)
  );

  ff #(.WIDTH(LINE_W), .RESET_VALUE('0)) u_d_rdata_ff (
    .clk(clk), .reset(reset), .en(d_resp), .d(mem_rdata), .q(d_rdata_q)
  );

  assign i_rdata = i_resp ? mem_rdata : i_rdata_q;
  assign d_rdata = d_resp ? mem_rdata : d_rdata_q;

  // mem_req is a decode of the registered state, never of the request inputs.
  assign mem_req = (state_q != ARB_IDLE);
  assign busy    = (state_q != ARB_IDLE);

endmodule
